// File: rtl/mcu51_pkg.sv
// Shared definitions for the 8051 core: ALU opcodes, sequencer FSM encoding,
// the latched request payload and common widths.
package mcu51_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OPND_W = 16;
    localparam int unsigned CNT_W  = 3;

    localparam int unsigned ALU_LAT_MAX = 7;

    localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [OP_W-1:0] ALU_ADDC = 5'd1;
    localparam logic [OP_W-1:0] ALU_SUBB = 5'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } seq_state_e;

    // Request fields still needed after accept (pass-1 operand byte is consumed at accept).
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic              wide;
        logic [DATA_W-1:0] opnd_hi;
        logic              wr;
    } alu_req_t;

    // Only the carry-chaining arithmetic ops can run as two passes.
    function automatic logic wide_capable(input logic [OP_W-1:0] op);
        return (op == ALU_ADD) || (op == ALU_ADDC) || (op == ALU_SUBB);
    endfunction

endpackage

// File: rtl/alu_seq.sv
// alu_seq: drives the 8051 ALU on behalf of the decoder. Owns ACC, B and PSW.CY,
// issues one ALU pass (narrow) or two chained passes (16-bit add/sub), waits
// ALU_LAT cycles per pass, then writes back and pulses done.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE without load)
//   req_op/req_wide/req_opnd/req_wr  request payload, latched at accept
//   load_en/load_acc/load_b/load_cy  direct register load, IDLE only
//   alu_op/alu_a/alu_b/alu_cin    registered ALU inputs
//   alu_ans/alu_cout              ALU results, sampled ALU_LAT cycles after issue
//   acc/breg/cy                   architectural registers
//   result/done/busy              last result, completion pulse, op in flight
module alu_seq
    import mcu51_pkg::*;
#(
    parameter int unsigned        ALU_LAT = 1,
    parameter logic [DATA_W-1:0]  ACC_RST = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_W-1:0]     req_op,
    input  logic                req_wide,
    input  logic [OPND_W-1:0]   req_opnd,
    input  logic                req_wr,
    input  logic                load_en,
    input  logic [DATA_W-1:0]   load_acc,
    input  logic [DATA_W-1:0]   load_b,
    input  logic                load_cy,
    output logic [OP_W-1:0]     alu_op,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic                alu_cin,
    input  logic [DATA_W-1:0]   alu_ans,
    input  logic                alu_cout,
    output logic [DATA_W-1:0]   acc,
    output logic [DATA_W-1:0]   breg,
    output logic                cy,
    output logic [OPND_W-1:0]   result,
    output logic                done,
    output logic                busy
);

    // Wait counter reload: the pass is sampled when the counter reads zero.
    localparam logic [CNT_W-1:0] LAT_RELOAD = CNT_W'(ALU_LAT - 1);

    seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    alu_req_t            req_q, req_d;
    logic [DATA_W-1:0]   p1_ans_q, p1_ans_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic                alu_cin_q, alu_cin_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   breg_q, breg_d;
    logic                cy_q, cy_d;
    logic [OPND_W-1:0]   result_q, result_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    // Ready is combinational on load_en so a same-cycle load wins over a request.
    assign req_ready = (state_q == IDLE) && !load_en && !rst;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            p1_ans_q  <= '0;
            alu_op_q  <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_cin_q <= 1'b0;
            acc_q     <= ACC_RST;
            breg_q    <= ACC_RST;
            cy_q      <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            p1_ans_q  <= p1_ans_d;
            alu_op_q  <= alu_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_cin_q <= alu_cin_d;
            acc_q     <= acc_d;
            breg_q    <= breg_d;
            cy_q      <= cy_d;
            result_q  <= result_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        p1_ans_d  = p1_ans_q;
        alu_op_d  = alu_op_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_cin_d = alu_cin_q;
        acc_d     = acc_q;
        breg_d    = breg_q;
        cy_d      = cy_q;
        result_d  = result_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        unique case (state_q)
            IDLE: begin
                if (load_en) begin
                    acc_d  = load_acc;
                    breg_d = load_b;
                    cy_d   = load_cy;
                end else if (req_valid) begin
                    req_d.op      = req_op;
                    req_d.wide    = req_wide && wide_capable(req_op);
                    req_d.opnd_hi = req_opnd[OPND_W-1:DATA_W];
                    req_d.wr      = req_wr;
                    alu_op_d      = req_op;
                    alu_a_d       = acc_q;
                    alu_b_d       = req_opnd[DATA_W-1:0];
                    alu_cin_d     = cy_q;
                    cnt_d         = LAT_RELOAD;
                    busy_d        = 1'b1;
                    state_d       = WAIT1;
                end
            end

            WAIT1: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (req_q.wide) begin
                    // Chain the high byte: carry/borrow of pass 1 feeds pass 2.
                    p1_ans_d  = alu_ans;
                    alu_op_d  = (req_q.op == ALU_ADD) ? ALU_ADDC : req_q.op;
                    alu_a_d   = breg_q;
                    alu_b_d   = req_q.opnd_hi;
                    alu_cin_d = alu_cout;
                    cnt_d     = LAT_RELOAD;
                    state_d   = WAIT2;
                end else begin
                    result_d = {8'h00, alu_ans};
                    if (req_q.wr) begin
                        acc_d = alu_ans;
                        cy_d  = alu_cout;
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            WAIT2: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    result_d = {alu_ans, p1_ans_q};
                    if (req_q.wr) begin
                        acc_d  = p1_ans_q;
                        breg_d = alu_ans;
                        cy_d   = alu_cout;
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign alu_op  = alu_op_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_cin = alu_cin_q;
    assign acc     = acc_q;
    assign breg    = breg_q;
    assign cy      = cy_q;
    assign result  = result_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequencer on the driving side of the 8051 ALU interface.
- Accepts operation requests from the decoder and owns ACC, B and PSW.CY.
- Drives the ALU inputs (alu_op, a_data, b_data, c_in), waits the ALU latency, captures ans/c_out and writes back.
- Chains two ALU passes for 16-bit add/subtract with carry propagation.

Parameters:
- ALU_LAT, 1, cycles from alu_* outputs changing to sampling alu_ans/alu_cout; legal 1..7.
- ACC_RST, 8'h00, reset value of acc and breg.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready.
- req_op  in  5  ALU opcode, passed to alu_op.
- req_wide  in  1  16-bit two-pass operation.
- req_opnd  in  16  operand; [7:0] pass 1, [15:8] pass 2.
- req_wr  in  1  write result to acc/breg/cy.
- load_en  in  1  direct register load.
- load_acc  in  8  acc load value.
- load_b  in  8  breg load value.
- load_cy  in  1  cy load value.
- alu_op  out  5  to ALU.
- alu_a  out  8  to ALU a_data.
- alu_b  out  8  to ALU b_data.
- alu_cin  out  1  to ALU c_in.
- alu_ans  in  8  from ALU.
- alu_cout  in  1  from ALU.
- acc  out  8  accumulator.
- breg  out  8  B register.
- cy  out  1  PSW carry.
- result  out  16  last result; high byte 0 for narrow ops.
- done  out  1  one-cycle completion pulse.
- busy  out  1  operation in flight.

Behaviour:
- Reset values: acc=breg=ACC_RST; cy=0; result=0; done=0; busy=0; alu_op/alu_a/alu_b/alu_cin=0; FSM=IDLE. req_ready=0 while rst is high.
- FSM states: IDLE, WAIT1, WAIT2. All alu_* outputs are registered.
- req_ready=1 only in IDLE with load_en=0.
- Load: load_en in IDLE writes acc/breg/cy at the edge. If load_en and req_valid are high in the same cycle, the load wins and the request is not accepted (ready=0). load_en outside IDLE is ignored.
- Accept at the edge ending cycle T, pass 1 setup:
  - alu_op=req_op, alu_a=acc, alu_b=req_opnd[7:0], alu_cin=cy.
  - Go to WAIT1; counter loads ALU_LAT-1.
- WAIT1:
  - Count down; sample alu_ans/alu_cout on the edge ending cycle T+ALU_LAT.
  - Narrow op: write back and return to IDLE.
  - Wide op: latch the pass-1 byte and carry, then set up pass 2 on the same edge and go to WAIT2:
    - alu_op = ADDC if req_op==ADD, else unchanged.
    - alu_a = breg; alu_b = req_opnd[15:8]; alu_cin = pass-1 cout.
- WAIT2: sample on the edge ending cycle T+2*ALU_LAT, write back, return to IDLE.
- req_wide is honoured only for ADD, ADDC, SUBB; for any other op it is treated as 0.
- Writeback edge:
  - result = {pass2 ans or 8'h00, pass1 ans}; done=1 for the following cycle.
  - If req_wr: acc = pass1 ans; breg = pass2 ans (wide only); cy = final cout.
  - If !req_wr: only result and done update.
- Latency: done is high in cycle T+ALU_LAT+1 (narrow) or T+2*ALU_LAT+1 (wide).
- req_ready is high in the done cycle, so back-to-back requests are allowed and see the written-back acc/cy.
- busy=1 in WAIT1/WAIT2.
- alu_* outputs hold their last values in IDLE.
- Request fields are latched at accept; changes after accept have no effect.
- Reset mid-operation: immediate abort, no writeback, all outputs return to reset values.

Decomposition:
- Shared package mcu51_pkg:
  - opcode constants ALU_ADD=5'd0, ALU_ADDC=5'd1, ALU_SUBB=5'd4;
  - FSM state encoding;
  - ALU_LAT_MAX=7.
- No sub-module; a single flat module (about 200 lines).

Test Plan (ALU_LAT=1 unless noted, behavioural ALU model):
- Reset: assert rst mid-cycle -> immediately acc=00, breg=00, cy=0, done=0, alu_*=0; after release req_ready=1.
- Narrow ADD: load acc=45; request ADD, opnd=0026, wr=1 at T -> cycle T+1 shows alu_op=0, alu_a=45, alu_b=26; done at T+2; acc=6B, cy=0, result=006B.
- Narrow ADDC: load acc=75, cy=1; request ADDC, opnd=0078 -> alu_cin=1; acc=EE, cy=0. Repeat with wr=0 -> result=00EE, acc stays 75.
- Wide ADD: load acc=FF, breg=12, cy=0; request ADD, wide, opnd=0001:
  - pass 1 a=FF, b=01, cout=1;
  - pass 2 alu_op=1, a=12, b=00, cin=1;
  - done at T+3; acc=00, breg=13, cy=0, result=1300.
- Contention: load_en and req_valid high in the same IDLE cycle -> load applied, req_ready=0, request accepted on the next cycle using the loaded acc. Back-to-back request in the done cycle -> accepted.
- ALU_LAT=3: narrow SUBB done at T+4; assert rst at T+2 -> no done pulse, acc/cy at reset values, busy=0.
